// File: rtl/mem_pkg.sv
// Shared definitions for the memory-side block responder: block geometry,
// the controller state encoding, and the beat address helper.
package mem_pkg;

    localparam int BLOCK_WIDTH = 128;
    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 4;
    localparam int TAG_BITS    = 32 - OFFSET_BITS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RESP    = 3'd3,
        ST_WB      = 3'd4
    } mem_state_e;

    // Word address of beat k inside the block identified by tag.
    function automatic logic [31:0] beat_addr(input logic [TAG_BITS-1:0] tag,
                                              input logic [1:0] k);
        return {tag, k, 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_buffer.sv
// One-entry dirty-block buffer: holds a captured write-back, compares its
// block tag against a refill address (including a block captured in the same
// cycle) and selects one word for the drain beats.
module mem_wb_buffer
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic [31:0]            cap_addr,
    input  logic [BLOCK_WIDTH-1:0] cap_data,
    input  logic                   clear,
    input  logic [31:0]            look_addr,
    input  logic [1:0]             word_sel,
    output logic                   valid,
    output logic [TAG_BITS-1:0]    tag,
    output logic                   hit,
    output logic [BLOCK_WIDTH-1:0] fwd_data,
    output logic [DATA_WIDTH-1:0]  word
);

    logic [BLOCK_WIDTH-1:0] data;
    logic                   unused_offsets;

    // Offset bits never take part in block matching.
    assign unused_offsets = ^{cap_addr[OFFSET_BITS-1:0], look_addr[OFFSET_BITS-1:0]};

    // Capture has priority; the controller only clears while the buffer is full,
    // and capture is only possible while it is empty, so they never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            tag   <= cap_addr[31:OFFSET_BITS];
            data  <= cap_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // A refill may match the stored block or one arriving this very cycle.
    assign hit = (valid && (tag == look_addr[31:OFFSET_BITS])) ||
                 (capture && (cap_addr[31:OFFSET_BITS] == look_addr[31:OFFSET_BITS]));
    assign fwd_data = valid ? data : cap_data;
    assign word     = data[word_sel*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/mem_block_ctrl.sv
// Memory-side responder: refills 128-bit blocks with four pipelined read
// beats, drains a buffered write-back with four write beats, and answers a
// refill that matches the buffered block straight from the buffer.
// Handshake: a transfer happens on a cycle where valid/req and ready are both
// high; ready depends only on state and flags, never on the request inputs.
module mem_block_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [31:0]            wb_addr,
    input  logic [BLOCK_WIDTH-1:0] wb_data,
    input  logic                   fill_req,
    output logic                   fill_ready,
    input  logic [31:0]            fill_addr,
    output logic                   fill_valid,
    output logic [BLOCK_WIDTH-1:0] fill_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic                   busy
);

    mem_state_e             state;
    logic [2:0]             issue_cnt;
    logic [1:0]             ret_cnt;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   last_fill;
    logic [MEM_LATENCY-1:0] rd_pipe;
    logic                   rd_ret;

    logic                   wb_fire;
    logic                   fill_fire;
    logic                   buf_valid;
    logic [TAG_BITS-1:0]    buf_tag;
    logic                   buf_hit;
    logic [BLOCK_WIDTH-1:0] buf_fwd;
    logic [DATA_WIDTH-1:0]  buf_word;
    logic [1:0]             buf_sel;
    logic                   buf_clear;

    assign wb_ready   = !buf_valid;
    assign fill_ready = (state == ST_IDLE) && !(buf_valid && last_fill);
    assign busy       = (state != ST_IDLE) || buf_valid;
    assign wb_fire    = wb_valid && wb_ready;
    assign fill_fire  = fill_req && fill_ready;
    assign buf_sel    = (state == ST_IDLE) ? 2'd0 : issue_cnt[1:0];
    assign buf_clear  = (state == ST_WB) && (issue_cnt == 3'd4);
    assign rd_ret     = rd_pipe[MEM_LATENCY-1];

    mem_wb_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (wb_fire),
        .cap_addr  (wb_addr),
        .cap_data  (wb_data),
        .clear     (buf_clear),
        .look_addr (fill_addr),
        .word_sel  (buf_sel),
        .valid     (buf_valid),
        .tag       (buf_tag),
        .hit       (buf_hit),
        .fwd_data  (buf_fwd),
        .word      (buf_word)
    );

    // Tracks issued read beats so returning data is recognised MEM_LATENCY later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= mem_en && !mem_we;
            for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Controller FSM with registered memory port and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            fill_tag   <= '0;
            last_fill  <= 1'b0;
            fill_valid <= 1'b0;
            fill_data  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Returning words land in order, independent of the issue side.
            if (rd_ret) begin
                fill_data[ret_cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                ret_cnt <= ret_cnt + 2'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (fill_fire) begin
                        if (buf_hit) begin
                            fill_data  <= buf_fwd;
                            fill_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            fill_tag  <= fill_addr[31:OFFSET_BITS];
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= beat_addr(fill_addr[31:OFFSET_BITS], 2'd0);
                            issue_cnt <= 3'd1;
                            state     <= ST_RD;
                        end
                    end else if (buf_valid) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= beat_addr(buf_tag, 2'd0);
                        mem_wdata <= buf_word;
                        issue_cnt <= 3'd1;
                        state     <= ST_WB;
                    end
                end
                ST_RD: begin
                    if (issue_cnt == 3'd4) begin
                        mem_en <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end else begin
                        mem_en    <= 1'b1;
                        mem_addr  <= beat_addr(fill_tag, issue_cnt[1:0]);
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_ret && (ret_cnt == 2'd3)) begin
                        fill_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    fill_valid <= 1'b0;
                    last_fill  <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_WB: begin
                    if (issue_cnt == 3'd4) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        last_fill <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        mem_addr  <= beat_addr(buf_tag, issue_cnt[1:0]);
                        mem_wdata <= buf_word;
                        issue_cnt <= issue_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
